puzzle_step_ctrl: RTL and testbench

- Sequencing controller for the 8-puzzle board datapath.
- Holds the 3x3 board and applies one blank-tile move per user button press. Moves are pulled from the solver's move stream over a valid/ready handshake.
- Flags goal reached or illegal move, and feeds board, blank position and step count to the top-level seven-segment display logic.

---
 rtl/puzzle_step_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_puzzle_step_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/puzzle_step_ctrl.sv
// 8-puzzle step controller: debounced button press pulls one solver move and applies it to the board.
// Optional hands-free replay is enabled by defining PUZZLE_AUTO_STEP_EN.
module puzzle_step_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter logic [35:0] INIT_BOARD      = 36'h870654321,
    parameter int unsigned INIT_BLANK      = 6,
    parameter logic [35:0] GOAL_BOARD      = 36'h087654321,
    parameter int unsigned AUTO_PERIOD     = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn,
    input  logic        mv_valid,
    input  logic [1:0]  mv_dir,
    input  logic        mv_last,
    output logic        mv_ready,
    output logic [35:0] board,
    output logic [3:0]  blank_pos,
    output logic [7:0]  step_cnt,
    output logic        done,
    output logic        err
);
    localparam int unsigned TILE_W = 4;
    localparam int unsigned CELLS  = 9;
    localparam int unsigned POS_W  = 4;
    localparam int unsigned STEP_W = 8;
    localparam int unsigned DB_W   = 16;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    typedef enum logic [2:0] {
        S_WAIT, S_FETCH, S_APPLY, S_CHECK, S_DONE, S_ERR
    } state_t;

    typedef struct packed {
        logic [1:0] dir;
        logic       last;
    } move_t;

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535 || AUTO_PERIOD == 0) begin : g_param_check
        $error("puzzle_step_ctrl: parameter out of range");
    end

    state_t state_q, state_d;
    move_t  mv_q, mv_d;
    logic [CELLS-1:0][TILE_W-1:0] board_q, board_d;
    logic [POS_W-1:0]  blank_d, nb_pos;
    logic [STEP_W-1:0] step_d;
    logic              done_d, err_d, ready_d, legal;

    logic              btn_s1, btn_s2, db_level, press, step_req;
    logic [DB_W-1:0]   db_cnt;

    // Two-flop synchronizer for the asynchronous button
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1 <= 1'b0;
            btn_s2 <= 1'b0;
        end else begin
            btn_s1 <= btn;
            btn_s2 <= btn_s1;
        end
    end

    // Debounce: level follows the input only after a full run of differing samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_level <= 1'b0;
            db_cnt   <= '0;
            press    <= 1'b0;
        end else begin
            press <= 1'b0;
            if (btn_s2 != db_level) begin
                if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    db_level <= btn_s2;
                    db_cnt   <= '0;
                    press    <= btn_s2;
                end else begin
                    db_cnt <= db_cnt + DB_W'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

`ifdef PUZZLE_AUTO_STEP_EN
    localparam int unsigned AUTO_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
    logic [AUTO_W-1:0] auto_cnt;
    logic              auto_pulse;

    // Free-running replay timer, one pulse per AUTO_PERIOD cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            auto_cnt   <= '0;
            auto_pulse <= 1'b0;
        end else if (auto_cnt == AUTO_W'(AUTO_PERIOD - 1)) begin
            auto_cnt   <= '0;
            auto_pulse <= 1'b1;
        end else begin
            auto_cnt   <= auto_cnt + AUTO_W'(1);
            auto_pulse <= 1'b0;
        end
    end

    assign step_req = press | auto_pulse;
`else
    assign step_req = press;
`endif

    // Legality of the latched move and the neighbour the blank swaps with
    always_comb begin
        legal  = 1'b0;
        nb_pos = blank_pos;
        unique case (mv_q.dir)
            DIR_UP: begin
                legal  = blank_pos >= POS_W'(3);
                nb_pos = blank_pos - POS_W'(3);
            end
            DIR_DOWN: begin
                legal  = blank_pos <= POS_W'(5);
                nb_pos = blank_pos + POS_W'(3);
            end
            DIR_LEFT: begin
                legal  = (blank_pos % POS_W'(3)) != POS_W'(0);
                nb_pos = blank_pos - POS_W'(1);
            end
            DIR_RIGHT: begin
                legal  = (blank_pos % POS_W'(3)) != POS_W'(2);
                nb_pos = blank_pos + POS_W'(1);
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        mv_d    = mv_q;
        board_d = board_q;
        blank_d = blank_pos;
        step_d  = step_cnt;
        done_d  = done;
        err_d   = err;
        unique case (state_q)
            S_WAIT: begin
                if (step_req) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (mv_valid) begin
                    mv_d    = '{dir: mv_dir, last: mv_last};
                    state_d = S_APPLY;
                end
            end
            S_APPLY: begin
                if (legal) begin
                    board_d[blank_pos] = board_q[nb_pos];
                    board_d[nb_pos]    = '0;
                    blank_d            = nb_pos;
                    step_d             = (step_cnt == '1) ? step_cnt : step_cnt + STEP_W'(1);
                    state_d            = S_CHECK;
                end else begin
                    err_d   = 1'b1;
                    state_d = S_ERR;
                end
            end
            S_CHECK: begin
                if (board_q == GOAL_BOARD) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else if (mv_q.last) begin
                    err_d   = 1'b1;
                    state_d = S_ERR;
                end else begin
                    state_d = S_WAIT;
                end
            end
            default: ;
        endcase
        // Registered ready tracks the state it will be asserted in
        ready_d = (state_d == S_FETCH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_WAIT;
            mv_q      <= '0;
            board_q   <= INIT_BOARD;
            blank_pos <= POS_W'(INIT_BLANK);
            step_cnt  <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            mv_ready  <= 1'b0;
        end else begin
            state_q   <= state_d;
            mv_q      <= mv_d;
            board_q   <= board_d;
            blank_pos <= blank_d;
            step_cnt  <= step_d;
            done      <= done_d;
            err       <= err_d;
            mv_ready  <= ready_d;
        end
    end

    assign board = board_q;

endmodule

// File: tb/tb_puzzle_step_ctrl.sv
// Self-checking bench for puzzle_step_ctrl: randomized stimulus against a tile-array reference model.
module tb_puzzle_step_ctrl;
    localparam int unsigned DB = 4;
    localparam int unsigned AP = 20;
    localparam logic [35:0] INIT_B = 36'h870654321;
    localparam logic [35:0] GOAL_B = 36'h087654321;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        btn = 1'b0;
    logic        mv_valid = 1'b0;
    logic [1:0]  mv_dir = 2'b00;
    logic        mv_last = 1'b0;
    logic        mv_ready;
    logic [35:0] board;
    logic [3:0]  blank_pos;
    logic [7:0]  step_cnt;
    logic        done;
    logic        err;

    int unsigned n_pass = 0;
    int unsigned n_checks = 0;

    puzzle_step_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .INIT_BOARD(INIT_B),
        .INIT_BLANK(6),
        .GOAL_BOARD(GOAL_B),
        .AUTO_PERIOD(AP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn(btn),
        .mv_valid(mv_valid), .mv_dir(mv_dir), .mv_last(mv_last),
        .mv_ready(mv_ready), .board(board), .blank_pos(blank_pos),
        .step_cnt(step_cnt), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: board as a tile array, moves as row/column arithmetic
    int m_tile[9];
    int m_blank, m_steps, m_run, m_edges;
    bit m_done, m_err, m_ready, m_busy, m_term, m_apply, m_check;
    bit m_last, m_lvl, m_press, m_auto, h1, h2;
    bit [1:0] m_dir;

    function automatic logic [35:0] m_board();
        logic [35:0] r;
        r = '0;
        for (int i = 0; i < 9; i++) r[4*i +: 4] = 4'(m_tile[i]);
        return r;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 9; i++) m_tile[i] = int'(INIT_B[4*i +: 4]);
        m_blank = 6; m_steps = 0; m_run = 0; m_edges = 0;
        m_done = 0; m_err = 0; m_ready = 0; m_busy = 0; m_term = 0;
        m_apply = 0; m_check = 0; m_last = 0; m_dir = 0;
        m_lvl = 0; m_press = 0; m_auto = 0; h1 = 0; h2 = 0;
    endfunction

    function automatic void model_step();
        bit p, b, sync, ok, n_apply, n_check;
        int row, col, np;
        p = m_press | m_auto;
        b = m_busy;
        n_apply = 0; n_check = 0; ok = 0; np = m_blank;
        // button: two-cycle delay, then a level change needs DB differing samples in a row
        sync = h2; h2 = h1; h1 = btn;
        m_press = 0;
        if (sync != m_lvl) begin
            m_run++;
            if (m_run == int'(DB)) begin m_lvl = sync; m_run = 0; m_press = sync; end
        end else m_run = 0;
        m_edges++;
`ifdef PUZZLE_AUTO_STEP_EN
        m_auto = (m_edges % int'(AP)) == 0;
`else
        m_auto = 0;
`endif
        if (m_check) begin
            if (m_board() == GOAL_B) begin m_done = 1; m_term = 1; end
            else if (m_last) begin m_err = 1; m_term = 1; end
            else m_busy = 0;
        end
        if (m_apply) begin
            row = m_blank / 3; col = m_blank % 3;
            case (m_dir)
                2'd0: begin ok = row > 0; np = m_blank - 3; end
                2'd1: begin ok = row < 2; np = m_blank + 3; end
                2'd2: begin ok = col > 0; np = m_blank - 1; end
                default: begin ok = col < 2; np = m_blank + 1; end
            endcase
            if (ok) begin
                m_tile[m_blank] = m_tile[np];
                m_tile[np] = 0;
                m_blank = np;
                if (m_steps < 255) m_steps++;
                n_check = 1;
            end else begin
                m_err = 1; m_term = 1;
            end
        end
        if (m_ready && mv_valid) begin
            m_dir = mv_dir; m_last = mv_last; m_ready = 0; n_apply = 1;
        end else if (!b && !m_term && p) begin
            m_busy = 1; m_ready = 1;
        end
        m_apply = n_apply;
        m_check = n_check;
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Cycle-by-cycle comparison shortly after each active edge
    initial begin
        forever begin
            @(posedge clk);
            #3;
            chk("board", board, m_board());
            chk("blank_pos", blank_pos, m_blank);
            chk("step_cnt", step_cnt, m_steps);
            chk("done", done, m_done);
            chk("err", err, m_err);
            chk("mv_ready", mv_ready, m_ready);
            chk("done_err_excl", done && err, 0);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; btn = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic press_btn();
        btn = 1'b1;
        repeat (DB + 4) @(negedge clk);
        btn = 1'b0;
        repeat (DB + 4) @(negedge clk);
    endtask

    int cnt, len;
    bit got;

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_board", board, 36'h870654321);
        chk("rst_blank", blank_pos, 6);
        chk("rst_steps", step_cnt, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_ready", mv_ready, 0);
        rst_n = 1'b1;

`ifdef PUZZLE_AUTO_STEP_EN
        // hands-free replay of right, right(last)
        mv_valid = 1'b1; mv_dir = 2'b11;
        repeat (45) begin
            mv_last = (m_steps >= 1);
            @(negedge clk);
        end
        chk("auto_done", done, 1);
        chk("auto_blank", blank_pos, 8);
        chk("auto_steps", step_cnt, 2);
`else
        // glitch shorter than the debounce window
        mv_valid = 1'b1; mv_dir = 2'b11; mv_last = 1'b0;
        btn = 1'b1;
        repeat (2) @(negedge clk);
        btn = 1'b0;
        repeat (15) @(negedge clk);
        chk("glitch_board", board, 36'h870654321);
        chk("glitch_steps", step_cnt, 0);

        // two clean presses solve the board
        press_btn();
        chk("r1_blank", blank_pos, 7);
        chk("r1_steps", step_cnt, 1);
        mv_last = 1'b1;
        press_btn();
        chk("r2_blank", blank_pos, 8);
        chk("r2_steps", step_cnt, 2);
        chk("r2_board", board, 36'h087654321);
        chk("r2_done", done, 1);
        chk("r2_err", err, 0);

        // illegal down from the bottom row
        do_reset();
        mv_dir = 2'b01; mv_last = 1'b0; mv_valid = 1'b1;
        press_btn();
        chk("ill_err", err, 1);
        chk("ill_board", board, 36'h870654321);
        chk("ill_steps", step_cnt, 0);
        chk("ill_ready", mv_ready, 0);

        // solver stalls for 10 ready cycles; a later press lands mid-move
        do_reset();
        mv_valid = 1'b0; mv_dir = 2'b00; mv_last = 1'b0;
        btn = 1'b1;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = mv_ready;
        end
        chk("stall_ready_seen", got, 1);
        btn = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cnt += int'(mv_ready);
            if (i == 6) btn = 1'b1;
            @(negedge clk);
        end
        chk("stall_ready_cycles", cnt, 10);
        mv_valid = 1'b1;
        @(negedge clk);
        mv_valid = 1'b0;
        repeat (4) @(negedge clk);
        btn = 1'b0;
        repeat (16) @(negedge clk);
        chk("stall_blank", blank_pos, 3);
        chk("stall_steps", step_cnt, 1);
        chk("stall_ready_after", mv_ready, 0);
`endif

        // randomized episodes
        for (int ep = 0; ep < 12; ep++) begin
            do_reset();
            cnt = 0;
            while (cnt < 250) begin
                len = $urandom_range(1, 9);
                btn = 1'($urandom_range(0, 1));
                for (int k = 0; k < len; k++) begin
                    mv_valid = 1'($urandom_range(0, 1));
                    if (ep % 3 == 0) begin
                        mv_dir = 2'b11;
                        mv_last = (m_steps == 1);
                    end else begin
                        mv_dir = 2'($urandom);
                        mv_last = ($urandom_range(0, 7) == 0);
                    end
                    if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
                    else rst_n = 1'b1;
                    @(negedge clk);
                end
                cnt += len;
            end
            rst_n = 1'b1;
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
